// File: rtl/tcp_vlg_pkg.sv
// Shared types and helpers for the TCP transmit scheduler.
package tcp_vlg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    REQ  = 2'd2
  } tcp_sched_state_t;

  typedef logic [31:0] tcp_seq_t;

  // True when x lies in (lo, hi] on the modular sequence circle.
  function automatic logic seq_in_range(input tcp_seq_t lo, input tcp_seq_t x,
                                        input tcp_seq_t hi);
    tcp_seq_t d;
    d = x - lo;
    return (d != '0) && (d <= (hi - lo));
  endfunction

endpackage

// File: rtl/tcp_vlg_tx_buf.sv
// Circular retransmission buffer: DEPTH x 8 simple dual-port RAM, registered read.
module tcp_vlg_tx_buf #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_dat,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_dat
);

  logic [7:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  // Read-before-write: a same-cycle write to rd_addr returns the old byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_dat <= 8'd0;
    else     rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/tcp_vlg_tx_sched.sv
// Transmit-side scheduler for one TCP connection: buffers user bytes, issues
// segment requests to the packet builder, tracks acks and rewinds on RTO.
module tcp_vlg_tx_sched
  import tcp_vlg_pkg::*;
#(
  parameter int AW          = 10,
  parameter int MSS         = 512,
  parameter int FORCE_TICKS = 1250,
  parameter int RTO_TICKS   = 125000,
  parameter int RTX_MAX     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          conn_est,
  input  logic [31:0]   init_seq,
  input  logic [7:0]    in_dat,
  input  logic          in_val,
  output logic          in_cts,
  input  logic [31:0]   rem_ack,
  input  logic          rem_ack_val,
  output logic          seg_req,
  output logic [31:0]   seg_seq,
  output logic [15:0]   seg_len,
  input  logic          seg_ack,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_dat,
  output logic          err_ovf,
  output logic [3:0]    rtx_cnt,
  output logic          rtx_lim
);

  // Handshakes: a user byte transfers on any cycle in_val is high while the
  // buffer has room; in_val may still be high the one cycle after in_cts
  // falls. A segment request holds seg_req/seg_seq/seg_len until seg_ack.

  localparam int                DEPTH   = 1 << AW;
  localparam tcp_seq_t          DEPTH_S = tcp_seq_t'(DEPTH);
  localparam tcp_seq_t          MSS_S   = tcp_seq_t'(MSS);
  localparam logic [15:0]       MSS_L   = 16'(MSS);
  localparam int                IW      = $clog2(FORCE_TICKS + 1);
  localparam int                TW      = $clog2(RTO_TICKS + 1);
  localparam logic [IW-1:0]     FORCE_C = IW'(FORCE_TICKS);
  localparam logic [TW-1:0]     RTO_C   = TW'(RTO_TICKS);

  tcp_sched_state_t state, state_nxt;

  tcp_seq_t ack_ptr, snd_ptr, wr_ptr;
  tcp_seq_t ack_nxt, snd_nxt, wr_nxt;
  tcp_seq_t seq_nxt;
  logic [15:0] len_nxt;
  logic [IW-1:0] idle_cnt, idle_nxt;
  logic [TW-1:0] rto_cnt, rto_cnt_nxt;
  logic rto_run, rto_run_nxt;
  logic [3:0] rtx_nxt;
  logic ovf_nxt, cts_nxt;
  logic conn_q, conn_rise;

  tcp_seq_t occ, unsent, snd_adv;
  logic wr_en, ack_ok, expire;

  assign conn_rise = conn_est & ~conn_q;
  assign occ       = wr_ptr - ack_ptr;
  assign unsent    = wr_ptr - snd_ptr;
  assign seg_req   = (state == REQ);
  assign rtx_lim   = ({28'd0, rtx_cnt} >= 32'(RTX_MAX));

  always_comb begin
    state_nxt   = state;
    ack_nxt     = ack_ptr;
    snd_nxt     = snd_ptr;
    wr_nxt      = wr_ptr;
    seq_nxt     = seg_seq;
    len_nxt     = seg_len;
    idle_nxt    = idle_cnt;
    rto_cnt_nxt = rto_cnt;
    rto_run_nxt = rto_run;
    rtx_nxt     = rtx_cnt;
    ovf_nxt     = err_ovf;
    wr_en       = 1'b0;
    snd_adv     = snd_ptr;
    ack_ok      = 1'b0;
    expire      = 1'b0;

    if (!conn_est) begin
      state_nxt = IDLE;
    end else if (conn_rise) begin
      state_nxt   = WAIT;
      ack_nxt     = init_seq;
      snd_nxt     = init_seq;
      wr_nxt      = init_seq;
      idle_nxt    = '0;
      rto_cnt_nxt = '0;
      rto_run_nxt = 1'b0;
      rtx_nxt     = 4'd0;
    end else if (state != IDLE) begin
      if (in_val) begin
        if (occ < DEPTH_S) begin
          wr_en  = 1'b1;
          wr_nxt = wr_ptr + 32'd1;
        end else begin
          ovf_nxt = 1'b1;
        end
      end

      if (wr_en)                idle_nxt = '0;
      else if (idle_cnt < FORCE_C) idle_nxt = idle_cnt + 1'b1;

      if (rto_run && (rto_cnt < RTO_C)) rto_cnt_nxt = rto_cnt + 1'b1;
      expire = rto_run && (rto_cnt >= RTO_C) && (snd_ptr != ack_ptr);

      // Ack window uses the snd_ptr that includes a same-cycle seg_ack.
      if ((state == REQ) && seg_ack) snd_adv = snd_ptr + {16'd0, seg_len};
      ack_ok = rem_ack_val && seq_in_range(ack_ptr, rem_ack, snd_adv);

      case (state)
        WAIT: begin
          if (expire && !ack_ok) begin
            snd_nxt     = ack_ptr;
            rto_run_nxt = 1'b0;
            rto_cnt_nxt = '0;
            if (rtx_cnt != 4'hF) rtx_nxt = rtx_cnt + 4'd1;
          end else if (unsent >= MSS_S) begin
            state_nxt = REQ;
            seq_nxt   = snd_ptr;
            len_nxt   = MSS_L;
          end else if ((unsent != '0) && (idle_cnt >= FORCE_C)) begin
            state_nxt = REQ;
            seq_nxt   = snd_ptr;
            len_nxt   = unsent[15:0];
          end
        end
        REQ: begin
          // An expiry seen here stays pending and is taken back in WAIT.
          if (seg_ack) begin
            snd_nxt   = snd_adv;
            state_nxt = WAIT;
            if (!rto_run) begin
              rto_run_nxt = 1'b1;
              rto_cnt_nxt = '0;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase

      if (ack_ok) begin
        ack_nxt     = rem_ack;
        rtx_nxt     = 4'd0;
        rto_cnt_nxt = '0;
        rto_run_nxt = (snd_adv != rem_ack);
      end
    end

    cts_nxt = conn_est && ((wr_nxt - ack_nxt) <= (DEPTH_S - 32'd2));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      conn_q  <= 1'b0;
      ack_ptr <= '0;
      snd_ptr <= '0;
      wr_ptr  <= '0;
      seg_seq <= '0;
      seg_len <= '0;
      idle_cnt <= '0;
      rto_cnt <= '0;
      rto_run <= 1'b0;
      rtx_cnt <= 4'd0;
      err_ovf <= 1'b0;
      in_cts  <= 1'b0;
    end else begin
      state   <= state_nxt;
      conn_q  <= conn_est;
      ack_ptr <= ack_nxt;
      snd_ptr <= snd_nxt;
      wr_ptr  <= wr_nxt;
      seg_seq <= seq_nxt;
      seg_len <= len_nxt;
      idle_cnt <= idle_nxt;
      rto_cnt <= rto_cnt_nxt;
      rto_run <= rto_run_nxt;
      rtx_cnt <= rtx_nxt;
      err_ovf <= ovf_nxt;
      in_cts  <= cts_nxt;
    end
  end

  tcp_vlg_tx_buf #(.AW(AW)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_dat  (in_dat),
    .rd_addr (rd_addr),
    .rd_dat  (rd_dat)
  );

endmodule

// File: tb/tb_tcp_vlg_tx_sched.sv
// Self-checking bench for tcp_vlg_tx_sched with a behavioural sequence model.
module tb_tcp_vlg_tx_sched;
  import tcp_vlg_pkg::*;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int MSS   = 512;
  localparam int FORCE = 1250;
  localparam int RTO   = 300;
  localparam int RTXM  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          conn_est = 1'b0;
  logic [31:0]   init_seq = '0;
  logic [7:0]    in_dat = '0;
  logic          in_val = 1'b0;
  logic          in_cts;
  logic [31:0]   rem_ack = '0;
  logic          rem_ack_val = 1'b0;
  logic          seg_req;
  logic [31:0]   seg_seq;
  logic [15:0]   seg_len;
  logic          seg_ack = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_dat;
  logic          err_ovf;
  logic [3:0]    rtx_cnt;
  logic          rtx_lim;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem_model [DEPTH];
  logic [31:0] m_wr, m_ack, m_snd;

  tcp_vlg_tx_sched #(
    .AW(AW), .MSS(MSS), .FORCE_TICKS(FORCE), .RTO_TICKS(RTO), .RTX_MAX(RTXM)
  ) dut (
    .clk(clk), .rst(rst), .conn_est(conn_est), .init_seq(init_seq),
    .in_dat(in_dat), .in_val(in_val), .in_cts(in_cts),
    .rem_ack(rem_ack), .rem_ack_val(rem_ack_val),
    .seg_req(seg_req), .seg_seq(seg_seq), .seg_len(seg_len), .seg_ack(seg_ack),
    .rd_addr(rd_addr), .rd_dat(rd_dat),
    .err_ovf(err_ovf), .rtx_cnt(rtx_cnt), .rtx_lim(rtx_lim)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic connect(input logic [31:0] isn);
    @(negedge clk);
    conn_est = 1'b0;
    in_val   = 1'b0;
    @(negedge clk);
    init_seq = isn;
    conn_est = 1'b1;
    @(negedge clk);
    m_wr = isn; m_ack = isn; m_snd = isn;
  endtask

  task automatic write_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_val = 1'b1;
      in_dat = 8'($urandom);
      mem_model[m_wr[AW-1:0]] = in_dat;
      m_wr = m_wr + 32'd1;
    end
    @(negedge clk);
    in_val = 1'b0;
  endtask

  task automatic wait_req(input int limit, output int n);
    n = 0;
    while (!seg_req && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!seg_req) begin
      checks++; failures++;
      $display("FAIL wait_req: no seg_req within %0d cycles", limit);
    end
  endtask

  task automatic ack_seg(input int len);
    seg_ack = 1'b1;
    m_snd = m_snd + 32'(len);
    @(negedge clk);
    seg_ack = 1'b0;
  endtask

  task automatic send_ack(input logic [31:0] a);
    logic [31:0] d;
    rem_ack = a;
    rem_ack_val = 1'b1;
    d = a - m_ack;
    if (d != 0 && d <= (m_snd - m_ack)) m_ack = a;
    @(negedge clk);
    rem_ack_val = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (in_cts !== 1'b0) begin failures++; $display("FAIL reset_cts: got %b want 0", in_cts); end
    checks++; if (seg_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", seg_req); end
    checks++; if (seg_seq !== 32'd0 || seg_len !== 16'd0) begin failures++; $display("FAIL reset_seg: got %h/%0d want 0/0", seg_seq, seg_len); end
    checks++; if (rd_dat !== 8'd0 || err_ovf !== 1'b0) begin failures++; $display("FAIL reset_dat_ovf: got %h/%b want 0/0", rd_dat, err_ovf); end
    checks++; if (rtx_cnt !== 4'd0 || rtx_lim !== 1'b0) begin failures++; $display("FAIL reset_rtx: got %0d/%b want 0/0", rtx_cnt, rtx_lim); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_mss();
    int n;
    logic [31:0] a;
    connect(32'h0000_1000);
    write_bytes(MSS);
    checks++; if (seg_req !== 1'b0) begin failures++; $display("FAIL mss_early: seg_req %b want 0", seg_req); end
    wait_req(10, n);
    checks++; if (n !== 1) begin failures++; $display("FAIL mss_latency: got %0d want 1", n); end
    checks++; if (seg_seq !== 32'h0000_1000) begin failures++; $display("FAIL mss_seq: got %h want 00001000", seg_seq); end
    checks++; if (seg_len !== 16'(MSS)) begin failures++; $display("FAIL mss_len: got %0d want %0d", seg_len, MSS); end
    for (int k = 0; k < 4; k++) begin
      a = 32'h0000_1000 + 32'($urandom_range(0, MSS - 1));
      rd_addr = a[AW-1:0];
      @(negedge clk);
      checks++; if (rd_dat !== mem_model[a[AW-1:0]]) begin failures++; $display("FAIL mss_rd: addr %h got %h want %h", a[AW-1:0], rd_dat, mem_model[a[AW-1:0]]); end
    end
    checks++; if (seg_req !== 1'b1 || seg_seq !== 32'h0000_1000) begin failures++; $display("FAIL mss_hold: req %b seq %h want 1/00001000", seg_req, seg_seq); end
    ack_seg(MSS);
    checks++; if (seg_req !== 1'b0) begin failures++; $display("FAIL mss_release: got %b want 0", seg_req); end
    send_ack(m_snd);
    checks++; if (dut.ack_ptr !== 32'h0000_1200) begin failures++; $display("FAIL mss_ack: got %h want 00001200", dut.ack_ptr); end
  endtask

  task automatic test_forced();
    int n;
    connect(32'h0000_1000);
    write_bytes(100);
    wait_req(FORCE + 20, n);
    checks++; if (n !== FORCE + 1) begin failures++; $display("FAIL force_latency: got %0d want %0d", n, FORCE + 1); end
    checks++; if (seg_len !== 16'd100 || seg_seq !== 32'h0000_1000) begin failures++; $display("FAIL force_seg: got %h/%0d want 00001000/100", seg_seq, seg_len); end
    ack_seg(100);
    send_ack(32'h0000_1064);
    checks++; if (dut.ack_ptr !== 32'h0000_1064) begin failures++; $display("FAIL force_ack: got %h want 00001064", dut.ack_ptr); end
    checks++; if (dut.rto_run !== 1'b0) begin failures++; $display("FAIL force_timer: run %b want 0", dut.rto_run); end
  endtask

  task automatic test_retransmit();
    int n;
    logic [31:0] isn;
    isn = 32'h2000_0000;
    connect(isn);
    write_bytes(MSS);
    wait_req(10, n);
    ack_seg(MSS);
    for (int i = 1; i <= RTXM; i++) begin
      wait_req(RTO + 20, n);
      m_snd = m_ack;
      checks++; if (n !== RTO + 2) begin failures++; $display("FAIL rtx_latency[%0d]: got %0d want %0d", i, n, RTO + 2); end
      checks++; if (rtx_cnt !== 4'(i)) begin failures++; $display("FAIL rtx_cnt[%0d]: got %0d want %0d", i, rtx_cnt, i); end
      checks++; if (rtx_lim !== (i >= RTXM)) begin failures++; $display("FAIL rtx_lim[%0d]: got %b want %b", i, rtx_lim, (i >= RTXM)); end
      checks++; if (seg_seq !== isn || dut.snd_ptr !== m_snd) begin failures++; $display("FAIL rtx_rewind[%0d]: seq %h snd %h want %h", i, seg_seq, dut.snd_ptr, isn); end
      if (i < RTXM) ack_seg(MSS);
    end
    // seg_ack and a covering ack in the same cycle
    rem_ack = isn + 32'(MSS);
    rem_ack_val = 1'b1;
    ack_seg(MSS);
    rem_ack_val = 1'b0;
    m_ack = isn + 32'(MSS);
    checks++; if (dut.ack_ptr !== m_ack || dut.snd_ptr !== m_snd) begin failures++; $display("FAIL rtx_simul: ack %h snd %h want %h", dut.ack_ptr, dut.snd_ptr, m_ack); end
    checks++; if (rtx_cnt !== 4'd0 || rtx_lim !== 1'b0 || dut.rto_run !== 1'b0) begin failures++; $display("FAIL rtx_clear: cnt %0d lim %b run %b want 0/0/0", rtx_cnt, rtx_lim, dut.rto_run); end
  endtask

  task automatic test_ack_wrap();
    int n;
    logic [31:0] isn, r;
    isn = 32'hFFFF_FF00;
    connect(isn);
    write_bytes(MSS);
    wait_req(10, n);
    checks++; if (seg_seq !== isn) begin failures++; $display("FAIL wrap_seq: got %h want %h", seg_seq, isn); end
    ack_seg(MSS);
    send_ack(32'h0000_0200);
    checks++; if (dut.ack_ptr !== isn) begin failures++; $display("FAIL wrap_beyond: got %h want %h", dut.ack_ptr, isn); end
    for (int k = 0; k < 6; k++) begin
      r = isn + 32'($urandom_range(0, 255));
      send_ack(r);
      checks++; if (dut.ack_ptr !== m_ack) begin failures++; $display("FAIL wrap_rand[%0d]: ack %h got %h want %h", k, r, dut.ack_ptr, m_ack); end
    end
    send_ack(32'h0000_0100);
    checks++; if (dut.ack_ptr !== 32'h0000_0100) begin failures++; $display("FAIL wrap_cross: got %h want 00000100", dut.ack_ptr); end
  endtask

  task automatic test_back_pressure();
    logic [31:0] isn, a;
    int acc, occ_fall, cyc, low_run;
    logic prev_cts;
    isn = $urandom;
    connect(isn);
    acc = 0; occ_fall = -1; cyc = 0; low_run = 0;
    prev_cts = in_cts;
    while (low_run < 4 && cyc < 3 * DEPTH) begin
      @(negedge clk);
      cyc++;
      if (prev_cts && !in_cts && occ_fall < 0) occ_fall = acc;
      in_val = in_cts || prev_cts;
      low_run = in_cts ? 0 : low_run + 1;
      prev_cts = in_cts;
      if (in_val) begin
        in_dat = 8'($urandom);
        if (acc < DEPTH) begin
          mem_model[m_wr[AW-1:0]] = in_dat;
          m_wr = m_wr + 32'd1;
          acc++;
        end
      end
    end
    in_val = 1'b0;
    checks++; if (occ_fall !== DEPTH - 1) begin failures++; $display("FAIL bp_cts_fall: occ %0d want %0d", occ_fall, DEPTH - 1); end
    checks++; if (dut.wr_ptr - isn !== 32'(DEPTH)) begin failures++; $display("FAIL bp_accepted: got %0d want %0d", dut.wr_ptr - isn, DEPTH); end
    checks++; if (err_ovf !== 1'b0 || in_cts !== 1'b0) begin failures++; $display("FAIL bp_ovf_clean: ovf %b cts %b want 0/0", err_ovf, in_cts); end
    for (int k = 0; k < 4; k++) begin
      a = 32'($urandom_range(0, DEPTH - 1));
      rd_addr = a[AW-1:0];
      @(negedge clk);
      checks++; if (rd_dat !== mem_model[a[AW-1:0]]) begin failures++; $display("FAIL bp_rd: addr %h got %h want %h", a[AW-1:0], rd_dat, mem_model[a[AW-1:0]]); end
    end
    in_val = 1'b1;
    in_dat = 8'hA5;
    @(negedge clk);
    in_val = 1'b0;
    checks++; if (err_ovf !== 1'b1 || dut.wr_ptr - isn !== 32'(DEPTH)) begin failures++; $display("FAIL bp_drop: ovf %b cnt %0d want 1/%0d", err_ovf, dut.wr_ptr - isn, DEPTH); end
  endtask

  task automatic test_abort();
    int n;
    connect(32'h0000_5000);
    write_bytes(MSS);
    wait_req(10, n);
    conn_est = 1'b0;
    @(negedge clk);
    checks++; if (seg_req !== 1'b0 || in_cts !== 1'b0 || dut.state !== IDLE) begin failures++; $display("FAIL abort_conn: req %b cts %b state %0d want 0/0/IDLE", seg_req, in_cts, dut.state); end
    connect(32'h0000_6000);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      in_val = 1'b1;
      in_dat = 8'($urandom);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (in_cts !== 1'b0 || seg_req !== 1'b0) begin failures++; $display("FAIL abort_rst_hs: cts %b req %b want 0/0", in_cts, seg_req); end
    checks++; if (seg_seq !== 32'd0 || seg_len !== 16'd0) begin failures++; $display("FAIL abort_rst_seg: got %h/%0d want 0/0", seg_seq, seg_len); end
    checks++; if (rd_dat !== 8'd0 || err_ovf !== 1'b0 || rtx_cnt !== 4'd0 || rtx_lim !== 1'b0) begin failures++; $display("FAIL abort_rst_misc: dat %h ovf %b rtx %0d lim %b want 0", rd_dat, err_ovf, rtx_cnt, rtx_lim); end
    in_val = 1'b0;
    conn_est = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_full_mss();
    test_forced();
    test_retransmit();
    test_ack_wrap();
    test_back_pressure();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
